// File: rtl/synth_cdc_ctrl.sv
// CPU-side controller for the cpu_to_synth_cdc handshake: MMIO writes land in shadow
// registers and are shipped as coherent snapshots over a 4-phase req/ack transfer.
module synth_cdc_voice #(
  parameter int FCW_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             snap,
  input  logic [FCW_W-1:0] data,
  output logic [FCW_W-1:0] cdc_fcw
);
  logic [FCW_W-1:0] shadow;

  // snapshot reads the pre-edge shadow, so a write on the snapshot edge waits for the next transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      cdc_fcw <= '0;
    end else begin
      if (wr)   shadow  <= data;
      if (snap) cdc_fcw <= shadow;
    end
  end
endmodule

module synth_cdc_ctrl #(
  parameter int N_VOICES    = 1,
  parameter int FCW_W       = 24,
  parameter int SHIFT_W     = 5,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [5:0]                wr_addr,
  input  logic [FCW_W-1:0]          wr_data,
  input  logic                      err_clr,
  input  logic                      cdc_ack,
  output logic                      cdc_req,
  output logic [N_VOICES*FCW_W-1:0] cdc_carrier_fcws,
  output logic [FCW_W-1:0]          cdc_mod_fcw,
  output logic [SHIFT_W-1:0]        cdc_mod_shift,
  output logic [N_VOICES-1:0]       cdc_note_en,
  output logic [SHIFT_W-1:0]        cdc_synth_shift,
  output logic                      busy,
  output logic                      dirty,
  output logic                      err,
  output logic [15:0]               xfer_cnt
);
  localparam int WD0   = (FCW_W > N_VOICES) ? FCW_W : N_VOICES;
  localparam int WD    = (WD0 > SHIFT_W) ? WD0 : SHIFT_W;
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    cnt;
  logic                                timed_out;
  logic [WD-1:0]                       wr_wide;
  logic                                voice_hit, wr_accept, start, tmo;
  logic [FCW_W-1:0]                    sh_mod_fcw;
  logic [SHIFT_W-1:0]                  sh_mod_shift, sh_synth_shift;
  logic [N_VOICES-1:0]                 sh_note_en;
  logic [N_VOICES-1:0][FCW_W-1:0]      car;

  assign wr_wide   = WD'(wr_data);
  assign voice_hit = wr_en && !wr_addr[5] && ({1'b0, wr_addr[4:0]} < 6'(N_VOICES));
  assign wr_accept = voice_hit || (wr_en && wr_addr[5:2] == 4'b1000);
  assign start     = (state == IDLE) && dirty && !cdc_ack && !err;
  assign tmo       = (state == REQ) && !cdc_ack && (cnt == CNT_LAST);
  assign busy      = (state != IDLE);

  for (genvar g = 0; g < N_VOICES; g++) begin : g_voice
    synth_cdc_voice #(.FCW_W(FCW_W)) u_voice (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (voice_hit && (wr_addr[4:0] == 5'(g))),
      .snap    (start),
      .data    (wr_data),
      .cdc_fcw (car[g])
    );
  end
  assign cdc_carrier_fcws = car;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mod_fcw      <= '0;
      sh_mod_shift    <= '0;
      sh_note_en      <= '0;
      sh_synth_shift  <= '0;
      cdc_mod_fcw     <= '0;
      cdc_mod_shift   <= '0;
      cdc_note_en     <= '0;
      cdc_synth_shift <= '0;
    end else begin
      if (wr_en) begin
        case (wr_addr)
          6'h20:   sh_mod_fcw     <= wr_data;
          6'h21:   sh_mod_shift   <= wr_wide[SHIFT_W-1:0];
          6'h22:   sh_note_en     <= wr_wide[N_VOICES-1:0];
          6'h23:   sh_synth_shift <= wr_wide[SHIFT_W-1:0];
          default: ;
        endcase
      end
      if (start) begin
        cdc_mod_fcw     <= sh_mod_fcw;
        cdc_mod_shift   <= sh_mod_shift;
        cdc_note_en     <= sh_note_en;
        cdc_synth_shift <= sh_synth_shift;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cdc_req   <= 1'b0;
      cnt       <= '0;
      timed_out <= 1'b0;
      dirty     <= 1'b0;
      err       <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= REQ;
          cdc_req   <= 1'b1;
          cnt       <= '0;
          timed_out <= 1'b0;
        end
        REQ: begin
          if (cdc_ack) begin
            state   <= REL;
            cdc_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= REL;
            cdc_req   <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: if (!cdc_ack) begin
          state <= IDLE;
          if (!timed_out) xfer_cnt <= xfer_cnt + 16'd1;
        end
        default: begin
          state   <= IDLE;
          cdc_req <= 1'b0;
        end
      endcase
      // later assignments win: a fresh write or a failed transfer keeps data pending
      if (start)     dirty <= 1'b0;
      if (tmo)       dirty <= 1'b1;
      if (wr_accept) dirty <= 1'b1;
      if (err_clr)   err   <= 1'b0;
      if (tmo)       err   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_synth_cdc_ctrl.sv
// Directed + randomized bench for synth_cdc_ctrl against a transaction-level shadow/snapshot model.
module tb_synth_cdc_ctrl;
  localparam int NV = 2, FW = 24, SW = 5, TO = 8;
  localparam int PW = NV*FW + FW + SW + NV + SW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, wr_en, err_clr, cdc_ack, cdc_req, busy, dirty, err;
  logic [5:0] wr_addr;
  logic [FW-1:0] wr_data, cdc_mod_fcw;
  logic [NV*FW-1:0] cdc_carrier_fcws;
  logic [SW-1:0] cdc_mod_shift, cdc_synth_shift;
  logic [NV-1:0] cdc_note_en;
  logic [15:0] xfer_cnt;

  synth_cdc_ctrl #(.N_VOICES(NV), .FCW_W(FW), .SHIFT_W(SW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_clr(err_clr), .cdc_ack(cdc_ack), .cdc_req(cdc_req),
    .cdc_carrier_fcws(cdc_carrier_fcws), .cdc_mod_fcw(cdc_mod_fcw),
    .cdc_mod_shift(cdc_mod_shift), .cdc_note_en(cdc_note_en),
    .cdc_synth_shift(cdc_synth_shift), .busy(busy), .dirty(dirty), .err(err),
    .xfer_cnt(xfer_cnt)
  );

  wire [PW-1:0] dut_pack = {cdc_carrier_fcws, cdc_mod_fcw, cdc_mod_shift, cdc_note_en, cdc_synth_shift};

  // model: shadow = last accepted write per field; snapshot = shadow just before the req edge
  logic [NV-1:0][FW-1:0] m_car;
  logic [FW-1:0] m_mod;
  logic [SW-1:0] m_ms, m_ss;
  logic [NV-1:0] m_ne;
  logic [PW-1:0] pre_pack, snap_pack;
  logic req_q;
  int total = 0, bad = 0, exp_xfer = 0, dly = 0;

  function automatic logic [PW-1:0] mpack();
    return {m_car, m_mod, m_ms, m_ne, m_ss};
  endfunction

  function automatic void mreset();
    m_car = '0; m_mod = '0; m_ms = '0; m_ss = '0; m_ne = '0;
    snap_pack = '0; req_q = 1'b0; exp_xfer = 0;
  endfunction

  function automatic void mwrite(logic [5:0] a, logic [FW-1:0] d);
    if (a < 6'(NV)) m_car[a[0]] = d;
    else case (a)
      6'h20: m_mod = d;
      6'h21: m_ms  = d[SW-1:0];
      6'h22: m_ne  = d[NV-1:0];
      6'h23: m_ss  = d[SW-1:0];
      default: ;
    endcase
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one clock: model sees the edge's write, then outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    pre_pack = mpack();
    if (rst_n && wr_en) mwrite(wr_addr, wr_data);
    @(negedge clk);
    if (cdc_req && !req_q) begin
      chk("snapshot", 128'(dut_pack), 128'(pre_pack));
      snap_pack = pre_pack;
    end else if (cdc_req || cdc_ack) begin
      chk("stable", 128'(dut_pack), 128'(snap_pack));
    end
    req_q = cdc_req;
  endtask

  task automatic wr(logic [5:0] a, logic [FW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic hs(int d);
    int n = 0;
    while (!cdc_req && n < 50) begin cyc(); n++; end
    chk("hs_req", 128'(cdc_req), 128'(1));
    repeat (d) cyc();
    cdc_ack = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (cdc_req && n < 50);
    chk("hs_req_fall", 128'(cdc_req), 128'(0));
    chk("hs_busy_rel", 128'(busy), 128'(1));
    cdc_ack = 1'b0;
    cyc();
    exp_xfer++;
    chk("hs_idle", 128'(busy), 128'(0));
    chk("hs_xfer", 128'(xfer_cnt), 128'(exp_xfer));
  endtask

  task automatic agent();
    if (cdc_req && !cdc_ack) begin
      if (dly == 0) cdc_ack = 1'b1; else dly--;
    end else if (cdc_ack && !cdc_req) begin
      cdc_ack = 1'b0;
      exp_xfer++;
      dly = int'($urandom_range(0, 4));
    end
  endtask

  initial begin
    logic [5:0] addrs [8];
    int n;
    addrs = '{6'h00, 6'h01, 6'h20, 6'h21, 6'h22, 6'h23, 6'h02, 6'h30};
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0; cdc_ack = 1'b0;
    mreset();
    repeat (3) @(negedge clk);
    chk("rst_pack", 128'(dut_pack), 128'(0));
    chk("rst_flags", 128'({cdc_req, busy, dirty, err}), 128'(0));
    chk("rst_xfer", 128'(xfer_cnt), 128'(0));
    rst_n = 1'b1;

    // basic transfer
    wr(6'h00, 24'h123456);
    chk("t1_dirty", 128'(dirty), 128'(1));
    chk("t1_noreq", 128'(cdc_req), 128'(0));
    cyc();
    chk("t1_req", 128'(cdc_req), 128'(1));
    chk("t1_car", 128'(cdc_carrier_fcws[FW-1:0]), 128'(24'h123456));
    chk("t1_clean", 128'(dirty), 128'(0));
    hs(2);
    chk("t1_dirty_end", 128'(dirty), 128'(0));

    // write during REQ goes out in the follow-up transfer
    wr(6'h00, 24'h000111);
    cyc();
    wr(6'h20, 24'h0ABCDE);
    chk("t2_mod_frozen", 128'(cdc_mod_fcw), 128'(0));
    chk("t2_dirty", 128'(dirty), 128'(1));
    hs(1);
    hs(1);
    chk("t2_mod", 128'(cdc_mod_fcw), 128'(24'h0ABCDE));

    // write on the snapshot edge
    wr(6'h00, 24'h000222);
    wr(6'h22, 24'h000001);
    chk("t3_req", 128'(cdc_req), 128'(1));
    chk("t3_ne_old", 128'(cdc_note_en), 128'(0));
    chk("t3_dirty", 128'(dirty), 128'(1));
    hs(1);
    hs(0);
    chk("t3_ne_new", 128'(cdc_note_en), 128'(1));

    // ack timeout
    wr(6'h21, 24'hFFFFE3);
    cyc();
    chk("t4_req", 128'(cdc_req), 128'(1));
    for (int i = 0; i < TO - 1; i++) begin
      cyc();
      chk("t4_req_hold", 128'(cdc_req), 128'(1));
    end
    cyc();
    chk("t4_req_drop", 128'(cdc_req), 128'(0));
    chk("t4_err", 128'(err), 128'(1));
    chk("t4_dirty", 128'(dirty), 128'(1));
    repeat (5) cyc();
    chk("t4_noreq", 128'(cdc_req), 128'(0));
    chk("t4_xfer", 128'(xfer_cnt), 128'(exp_xfer));
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("t4_err_clr", 128'(err), 128'(0));
    chk("t4_noreq2", 128'(cdc_req), 128'(0));
    cyc();
    chk("t4_req2", 128'(cdc_req), 128'(1));
    chk("t4_ms", 128'(cdc_mod_shift), 128'(5'h03));
    hs(2);

    // async reset mid-REQ, then unmapped writes
    wr(6'h23, 24'h000007);
    cyc();
    chk("t5_req", 128'(cdc_req), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_req", 128'(cdc_req), 128'(0));
    chk("t5_async_pack", 128'(dut_pack), 128'(0));
    chk("t5_async_flags", 128'({busy, dirty, err, xfer_cnt}), 128'(0));
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
    wr(6'h05, 24'hABCDEF);
    wr(6'h30, 24'hABCDEF);
    wr(6'h02, 24'hABCDEF);
    repeat (2) cyc();
    chk("t5_unmapped_dirty", 128'(dirty), 128'(0));
    chk("t5_unmapped_req", 128'(cdc_req), 128'(0));

    // stale ack in IDLE holds off the request
    cdc_ack = 1'b1;
    wr(6'h01, 24'h000055);
    repeat (3) cyc();
    chk("t6_noreq", 128'(cdc_req), 128'(0));
    chk("t6_dirty", 128'(dirty), 128'(1));
    cdc_ack = 1'b0;
    cyc();
    chk("t6_req", 128'(cdc_req), 128'(1));
    chk("t6_car1", 128'(cdc_carrier_fcws[2*FW-1:FW]), 128'(24'h000055));
    hs(1);

    // randomized writes against a well-behaved ack agent
    for (int i = 0; i < 600; i++) begin
      agent();
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = addrs[$urandom_range(0, 7)];
      wr_data = FW'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    n = 0;
    while ((busy || dirty || cdc_req || cdc_ack) && n < 300) begin
      agent();
      cyc();
      n++;
    end
    chk("rnd_drained", 128'({busy, dirty, cdc_req, cdc_ack}), 128'(0));
    chk("rnd_xfer", 128'(xfer_cnt), 128'(exp_xfer));
    chk("rnd_final", 128'(dut_pack), 128'(mpack()));
    chk("rnd_err", 128'(err), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
